// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multicycle control FSM: state encoding, opcodes, ALU selects, strobe bundle.
// Also holds the opcode-to-next-state mapping used in DECODE.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_source;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;

    function automatic state_t decode_next(input logic [6:0] op);
        case (op)
            OP_RTYPE:          return S_EXEC_R;
            OP_ITYPE:          return S_EXEC_I;
            OP_LOAD, OP_STORE: return S_MEM_ADDR;
            OP_BRANCH:         return S_BRANCH;
            default:           return S_HALT;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Strobe decoder: maps the current FSM state (plus mem_ready/zero where needed) to datapath controls.
// Latency: purely combinational, zero cycles.
// Backpressure: none; mem_ready only gates ir_write/pc_write in FETCH, zero gates pc_write in BRANCH.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic       zero,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_WB_ALU: ctrl.reg_write = 1'b1;
            S_WB_MEM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            // BEQ: A=rs1, B=rs2, subtract; the PC takes the target computed in DECODE only on zero.
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_source = 1'b1;
                ctrl.pc_write  = zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM; `define MC_CTRL_PERF_EN adds the 32-bit retired-instruction counter.
// Latency: 3 (branch), 4 (R/I/store), 5 (load) cycles from FETCH at zero wait states.
// Backpressure: FETCH/MEM_RD/MEM_WR stall on mem_ready; MEM_TIMEOUT stalled cycles -> sticky HALT.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [1:0]  alu_op,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_source,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic [3:0]  state,
    output logic        illegal,
    output logic [31:0] instr_count
);

    localparam int CW = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;

    state_t        state_q;
    state_t        mem_next;
    logic [CW-1:0] wait_cnt;
    logic          timeout;
    ctrl_t         ctrl;

    // The counter holds the number of stalled cycles already spent, so the last allowed one is MEM_TIMEOUT-1.
    assign timeout = (wait_cnt == CW'(MEM_TIMEOUT - 1));

    always_comb begin
        mem_next = S_IDLE;
        if (state_q == S_FETCH)       mem_next = S_DECODE;
        else if (state_q == S_MEM_RD) mem_next = S_WB_MEM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wait_cnt <= '0;
            illegal  <= 1'b0;
        end else begin
            wait_cnt <= '0;
            case (state_q)
                S_IDLE: if (run) state_q <= S_FETCH;
                S_FETCH, S_MEM_RD, S_MEM_WR: begin
                    if (mem_ready) begin
                        state_q <= mem_next;
                    end else if (timeout) begin
                        state_q <= S_HALT;
                        illegal <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    state_q <= decode_next(opcode);
                    if (decode_next(opcode) == S_HALT) illegal <= 1'b1;
                end
                S_EXEC_R, S_EXEC_I:           state_q <= S_WB_ALU;
                S_MEM_ADDR:                   state_q <= (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
                S_WB_ALU, S_WB_MEM, S_BRANCH: state_q <= S_IDLE;
                S_HALT:                       state_q <= S_HALT;
                default: begin
                    state_q <= S_HALT;
                    illegal <= 1'b1;
                end
            endcase
        end
    end

`ifdef MC_CTRL_PERF_EN
    logic retire;
    assign retire = (state_q == S_WB_ALU) || (state_q == S_WB_MEM) || (state_q == S_BRANCH) ||
                    ((state_q == S_MEM_WR) && mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      instr_count <= '0;
        else if (retire) instr_count <= instr_count + 32'd1;
    end
`else
    assign instr_count = '0;
`endif

    mc_ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .zero      (zero),
        .ctrl      (ctrl)
    );

    assign state      = state_q;
    assign alu_op     = ctrl.alu_op;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign iord       = ctrl.iord;
    assign ir_write   = ctrl.ir_write;
    assign pc_write   = ctrl.pc_write;
    assign pc_source  = ctrl.pc_source;
    assign reg_write  = ctrl.reg_write;
    assign mem_to_reg = ctrl.mem_to_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed per-cycle vectors feed an expectation queue, a negedge monitor checks them.
module tb_multicycle_control;
    import mc_ctrl_pkg::*;

`ifdef MC_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_X  = 7'b1111111;

    // {alu_op, alu_src_a, alu_src_b, mem_read, mem_write, iord, ir_write, pc_write, pc_source, reg_write, mem_to_reg}
    localparam logic [12:0] X0  = {2'b00, 1'b0, 2'b00, 8'b00000000};
    localparam logic [12:0] XFR = {2'b00, 1'b0, 2'b01, 8'b10011000};
    localparam logic [12:0] XFW = {2'b00, 1'b0, 2'b01, 8'b10000000};
    localparam logic [12:0] XD  = {2'b00, 1'b0, 2'b10, 8'b00000000};
    localparam logic [12:0] XER = {2'b10, 1'b1, 2'b00, 8'b00000000};
    localparam logic [12:0] XEI = {2'b10, 1'b1, 2'b10, 8'b00000000};
    localparam logic [12:0] XMA = {2'b00, 1'b1, 2'b10, 8'b00000000};
    localparam logic [12:0] XMR = {2'b00, 1'b0, 2'b00, 8'b10100000};
    localparam logic [12:0] XMW = {2'b00, 1'b0, 2'b00, 8'b01100000};
    localparam logic [12:0] XWA = {2'b00, 1'b0, 2'b00, 8'b00000010};
    localparam logic [12:0] XWM = {2'b00, 1'b0, 2'b00, 8'b00000011};
    localparam logic [12:0] XB1 = {2'b01, 1'b1, 2'b00, 8'b00001100};
    localparam logic [12:0] XB0 = {2'b01, 1'b1, 2'b00, 8'b00000100};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic [1:0]  alu_op;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        mem_read, mem_write, iord, ir_write, pc_write, pc_source, reg_write, mem_to_reg;
    logic [3:0]  state;
    logic        illegal;
    logic [31:0] instr_count;

    logic [49:0] exp_q[$];
    string       name_q[$];
    logic [31:0] exp_icnt = 32'd0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .alu_op      (alu_op),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .iord        (iord),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_source   (pc_source),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .state       (state),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    task automatic expect_out(input string nm, input state_t st, input logic [12:0] x, input logic ill);
        logic [31:0] ic;
        ic = PERF ? exp_icnt : 32'd0;
        exp_q.push_back({st, x, ill, ic});
        name_q.push_back(nm);
    endtask

    // Drives one cycle's inputs just after a rising edge and queues that cycle's expected outputs.
    task automatic step(input string nm, input logic r, input logic [6:0] op, input logic rdy,
                        input logic z, input state_t st, input logic [12:0] x, input logic ill);
        run       = r;
        opcode    = op;
        mem_ready = rdy;
        zero      = z;
        expect_out(nm, st, x, ill);
        @(posedge clk);
        #1;
    endtask

    task automatic begin_instr(input string p, input logic [6:0] op, input logic z);
        step({p, "_idle"},   1'b1, op, 1'b1, z, S_IDLE,   X0,  1'b0);
        step({p, "_fetch"},  1'b1, op, 1'b1, z, S_FETCH,  XFR, 1'b0);
        step({p, "_decode"}, 1'b1, op, 1'b1, z, S_DECODE, XD,  1'b0);
    endtask

    // Monitor: compares the full output vector against the oldest queued expectation.
    initial begin
        logic [49:0] got;
        logic [49:0] e;
        string       nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                got = {state, alu_op, alu_src_a, alu_src_b, mem_read, mem_write, iord, ir_write,
                       pc_write, pc_source, reg_write, mem_to_reg, illegal, instr_count};
                n_tests++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL %s: got state=%0d ctrl=%b ill=%b icnt=%0d, expected state=%0d ctrl=%b ill=%b icnt=%0d",
                             nm, got[49:46], got[45:33], got[32], got[31:0], e[49:46], e[45:33], e[32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step("reset_idle", 1'b0, OP_R, 1'b0, 1'b0, S_IDLE, X0, 1'b0);
        rst_n = 1'b1;
        step("idle_no_run", 1'b0, OP_R, 1'b1, 1'b0, S_IDLE, X0, 1'b0);

        begin_instr("r", OP_R, 1'b0);
        step("r_exec", 1'b1, OP_R, 1'b1, 1'b0, S_EXEC_R, XER, 1'b0);
        step("r_wb",   1'b1, OP_R, 1'b1, 1'b0, S_WB_ALU, XWA, 1'b0);
        exp_icnt++;

        begin_instr("ld", OP_LD, 1'b0);
        step("ld_addr", 1'b1, OP_LD, 1'b1, 1'b0, S_MEM_ADDR, XMA, 1'b0);
        for (int i = 0; i < 3; i++)
            step("ld_wait", 1'b1, OP_LD, 1'b0, 1'b0, S_MEM_RD, XMR, 1'b0);
        step("ld_rd",   1'b1, OP_LD, 1'b1, 1'b0, S_MEM_RD, XMR, 1'b0);
        step("ld_wb",   1'b1, OP_LD, 1'b1, 1'b0, S_WB_MEM, XWM, 1'b0);
        exp_icnt++;

        begin_instr("st", OP_ST, 1'b0);
        step("st_addr", 1'b1, OP_ST, 1'b1, 1'b0, S_MEM_ADDR, XMA, 1'b0);
        step("st_wr",   1'b1, OP_ST, 1'b1, 1'b0, S_MEM_WR,   XMW, 1'b0);
        exp_icnt++;

        begin_instr("beq1", OP_B, 1'b1);
        step("beq1_br", 1'b1, OP_B, 1'b1, 1'b1, S_BRANCH, XB1, 1'b0);
        exp_icnt++;
        begin_instr("beq0", OP_B, 1'b0);
        step("beq0_br", 1'b1, OP_B, 1'b1, 1'b0, S_BRANCH, XB0, 1'b0);
        exp_icnt++;

        begin_instr("i", OP_I, 1'b0);
        step("i_exec", 1'b1, OP_I, 1'b1, 1'b0, S_EXEC_I, XEI, 1'b0);
        step("i_wb",   1'b1, OP_I, 1'b1, 1'b0, S_WB_ALU, XWA, 1'b0);
        exp_icnt++;

        begin_instr("ill", OP_X, 1'b0);
        for (int i = 0; i < 20; i++)
            step("halt_hold", 1'b1, OP_X, 1'b1, 1'b1, S_HALT, X0, 1'b1);
        rst_n = 1'b0;
        exp_icnt = 32'd0;
        step("halt_reset", 1'b0, OP_R, 1'b0, 1'b0, S_IDLE, X0, 1'b0);
        rst_n = 1'b1;

        step("to_idle", 1'b1, OP_R, 1'b0, 1'b0, S_IDLE, X0, 1'b0);
        for (int i = 0; i < 4; i++)
            step("to_fetch_wait", 1'b1, OP_R, 1'b0, 1'b0, S_FETCH, XFW, 1'b0);
        step("to_halt", 1'b1, OP_R, 1'b1, 1'b0, S_HALT, X0, 1'b1);
        rst_n = 1'b0;
        step("to_reset", 1'b0, OP_R, 1'b0, 1'b0, S_IDLE, X0, 1'b0);
        rst_n = 1'b1;

        // Reset lands between edges while EXEC_R is active; IDLE must show before the next edge.
        begin_instr("ab", OP_R, 1'b0);
        #2;
        rst_n = 1'b0;
        expect_out("abort_idle", S_IDLE, X0, 1'b0);
        @(posedge clk);
        #1;
        step("abort_hold", 1'b1, OP_R, 1'b1, 1'b0, S_IDLE, X0, 1'b0);
        rst_n = 1'b1;

        begin_instr("rel", OP_R, 1'b0);
        step("rel_exec", 1'b1, OP_R, 1'b1, 1'b0, S_EXEC_R, XER, 1'b0);
        step("rel_wb",   1'b1, OP_R, 1'b1, 1'b0, S_WB_ALU, XWA, 1'b0);
        exp_icnt++;
        begin_instr("st2", OP_ST, 1'b0);
        step("st2_addr", 1'b1, OP_ST, 1'b1, 1'b0, S_MEM_ADDR, XMA, 1'b0);
        step("st2_wr",   1'b1, OP_ST, 1'b1, 1'b0, S_MEM_WR,   XMW, 1'b0);
        exp_icnt++;
        begin_instr("b2", OP_B, 1'b1);
        step("b2_br", 1'b1, OP_B, 1'b1, 1'b1, S_BRANCH, XB1, 1'b0);
        exp_icnt++;
        step("count3", 1'b0, OP_R, 1'b0, 1'b0, S_IDLE, X0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++)
            @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum cycles to wait for mem_ready in any memory state before the error halt.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 run  input  1  enables leaving IDLE to start an instruction fetch.
REQ-005 opcode  input  7  instruction[6:0], valid from the IR from DECODE onward.
REQ-006 zero  input  1  ALU zero flag, sampled in BRANCH.
REQ-007 mem_ready  input  1  memory handshake: the access completes in the cycle it is high.
REQ-008 alu_op  output  2  to the ALU control block: 00 add, 01 sub, 10 decode funct, 11 never driven.
REQ-009 alu_src_a  output  1  ALU A operand select: 0 PC, 1 rs1.
REQ-010 alu_src_b  output  2  ALU B operand select: 00 rs2, 01 constant 4, 10 immediate.
REQ-011 Strobe outputs, each 1 bit: mem_read, mem_write, iord, ir_write, pc_write, pc_source, reg_write, mem_to_reg.
REQ-012 state  output  4  current state encoding, for debug.
REQ-013 illegal  output  1  sticky flag: illegal opcode or memory timeout.
REQ-014 instr_count  output  32  count of retired instructions (see Configuration).

Function
REQ-015 Moore FSM; all outputs SHALL decode from the state register only, except pc_write in FETCH and BRANCH and ir_write in FETCH, which also depend on mem_ready and zero as stated below.
REQ-016 States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, HALT.
REQ-017 IDLE: all strobes 0; go to FETCH when run=1, otherwise stay.
REQ-018 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00.
- When mem_ready=1: ir_write=1 and pc_write=1 in that cycle, then go to DECODE.
- Otherwise stay in FETCH.
REQ-019 DECODE: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target); next state chosen from opcode:
- 0110011 -> EXEC_R
- 0010011 -> EXEC_I
- 0000011 or 0100011 -> MEM_ADDR
- 1100011 -> BRANCH
- any other value -> HALT, with illegal set.
REQ-020 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10, then WB_ALU.
REQ-021 EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=10, then WB_ALU.
REQ-022 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00, then MEM_RD for a load or MEM_WR for a store.
REQ-023 MEM_RD and MEM_WR: iord=1, with mem_read or mem_write held high until mem_ready=1; then MEM_RD goes to WB_MEM and MEM_WR goes to IDLE.
REQ-024 WB_ALU: reg_write=1, mem_to_reg=0, then IDLE. WB_MEM: reg_write=1, mem_to_reg=1, then IDLE.
REQ-025 BRANCH (BEQ): alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=1, pc_write=zero, then IDLE.
REQ-026 Zero-wait latency, counted from the FETCH entry cycle to the cycle before IDLE re-entry: R-type and I-type 4, load 5, store 4, branch 3.
REQ-027 Wait counter: 8+ bits, cleared on entry to each memory state; when it reaches MEM_TIMEOUT without mem_ready, go to HALT and set illegal.
REQ-028 HALT: all strobes 0; held until reset; run and mem_ready are ignored.
REQ-029 mem_ready high outside FETCH, MEM_RD and MEM_WR SHALL be ignored.

Reset
REQ-030 rst_n low SHALL asynchronously force state=IDLE, illegal=0, wait counter=0 and instr_count=0, so that all strobes and alu_op read 0.
REQ-031 Reset asserted mid-instruction SHALL abort the instruction with no further strobes; a release into IDLE with run=1 fetches on the following edge.

Configuration
REQ-032 Macro MC_CTRL_PERF_EN.
- Defined: instr_count increments by 1, wrapping at 2^32, on each transition into IDLE from WB_ALU, WB_MEM, MEM_WR or BRANCH.
- Undefined: instr_count is tied to 0 and no counter flops exist.

Structure
REQ-033 Package mc_ctrl_pkg SHALL hold the state typedef, the opcode constants, the alu_op constants and the alu_src_b constants.
REQ-034 Sub-module mc_ctrl_decode: combinational mapping of state, mem_ready and zero to the output strobes; the FSM and counters stay in multicycle_control.

Verification
REQ-035 Reset then run=1, opcode=0110011, mem_ready=1 constant -> states FETCH, DECODE, EXEC_R, WB_ALU, IDLE; alu_op=10 in EXEC_R; reg_write=1 for exactly 1 cycle.
REQ-036 Load, opcode=0000011, mem_ready low for 3 cycles in MEM_RD -> mem_read and iord held 4 cycles; WB_MEM with mem_to_reg=1.
REQ-037 BEQ, opcode=1100011: zero=1 -> pc_write=1, pc_source=1, alu_op=01; zero=0 -> pc_write=0.
REQ-038 opcode=1111111 -> HALT, illegal=1 and all strobes 0 for the next 20 cycles; rst_n pulse -> IDLE, illegal=0.
REQ-039 mem_ready held 0 in FETCH with MEM_TIMEOUT=4 -> HALT after 4 cycles, illegal=1.
REQ-040 rst_n driven low mid-EXEC_R between clock edges -> state=IDLE immediately with no reg_write; with MC_CTRL_PERF_EN, 3 completed instructions -> instr_count=3.
